// File: rtl/waffle_ctrl.sv
// -----------------------------------------------------------------------------
// waffle_ctrl -- top-level sequencer for the waffle solver.
//
// A job runs in four phases:
//   IDLE : waits for start
//   LOAD : accepts IMG_ROWS*IMG_COLS image words from the host, writes word k
//          to RAM address k (row-major, address = {row, col})
//   RUN  : solver released from reset; both RAM ports belong to the solver
//   HOLD : latched result offered to the host until result_ready is seen
// abort returns to IDLE from any phase and discards any partial work.
//
// Optional feature (macro WAFFLE_CTRL_CYCLE_COUNT_EN):
//   adds output run_cycles, the number of RUN cycles before slv_complete,
//   latched together with result.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, abort                job control pulses
//   in_valid/in_ready/in_data   host image word stream
//   result_valid/result_ready   result handshake, result = latched MCSS value
//   busy                        high in LOAD, RUN and HOLD
//   ram_addr1/2, ram_wdata1,
//   ram_we1, ram_rdata1/2       shared dual-port RAM (asynchronous read)
//   slv_rst                     solver reset (registered)
//   slv_addr1/2, slv_out_data1,
//   slv_we, slv_complete,
//   slv_result                  solver memory requests and status
//   slv_in_data1/2              RAM read data forwarded to the solver
// -----------------------------------------------------------------------------
module waffle_ctrl #(
  parameter int IMG_ROWS = 2,
  parameter int IMG_COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic [31:0] ram_addr1,
  output logic [31:0] ram_addr2,
  output logic [31:0] ram_wdata1,
  output logic        ram_we1,
  input  logic [31:0] ram_rdata1,
  input  logic [31:0] ram_rdata2,
  output logic        slv_rst,
  input  logic [31:0] slv_addr1,
  input  logic [31:0] slv_addr2,
  input  logic [31:0] slv_out_data1,
  input  logic        slv_we,
  input  logic        slv_complete,
  input  logic [31:0] slv_result,
  output logic [31:0] slv_in_data1,
`ifdef WAFFLE_CTRL_CYCLE_COUNT_EN
  output logic [31:0] run_cycles,
`endif
  output logic [31:0] slv_in_data2
);

  localparam int FRAME_WORDS = IMG_ROWS * IMG_COLS;
  localparam int CNT_W       = $clog2(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             result_valid_r;
  logic             slv_rst_r;
  logic [31:0]      result_r;
  logic             accept_s;

  // in_ready_r is high exactly while in LOAD, so this is a host word handshake.
  assign accept_s = in_valid & in_ready_r;

  // Sequencer: phase, load counter and every registered status output.
  // abort takes priority over every other event in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      count_r        <= '0;
      in_ready_r     <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      slv_rst_r      <= 1'b1;
      result_r       <= 32'd0;
    end else if (abort) begin
      state_r        <= IDLE;
      count_r        <= '0;
      in_ready_r     <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      slv_rst_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD;
            count_r    <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (count_r == LAST_WORD) begin
              // Solver leaves reset on the same edge that enters RUN.
              state_r    <= RUN;
              count_r    <= '0;
              in_ready_r <= 1'b0;
              slv_rst_r  <= 1'b0;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (slv_complete) begin
            state_r        <= HOLD;
            result_r       <= slv_result;
            result_valid_r <= 1'b1;
            slv_rst_r      <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          count_r        <= '0;
          in_ready_r     <= 1'b0;
          busy_r         <= 1'b0;
          result_valid_r <= 1'b0;
          slv_rst_r      <= 1'b1;
        end
      endcase
    end
  end

  // RAM port steering: host writes through port 1 in LOAD, the solver owns
  // both ports in RUN, and everything is parked at zero otherwise.
  always_comb begin
    ram_we1    = 1'b0;
    ram_addr1  = 32'd0;
    ram_addr2  = 32'd0;
    ram_wdata1 = 32'd0;
    case (state_r)
      LOAD: begin
        // An abort in the same cycle cancels the write.
        ram_we1    = accept_s & ~abort;
        ram_addr1  = {{(32 - CNT_W){1'b0}}, count_r};
        ram_wdata1 = in_data;
      end
      RUN: begin
        ram_we1    = slv_we;
        ram_addr1  = slv_addr1;
        ram_addr2  = slv_addr2;
        ram_wdata1 = slv_out_data1;
      end
      default: begin
        ram_we1    = 1'b0;
        ram_addr1  = 32'd0;
        ram_addr2  = 32'd0;
        ram_wdata1 = 32'd0;
      end
    endcase
  end

`ifdef WAFFLE_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_r;
  logic [31:0] run_cycles_r;

  // RUN-cycle counter: zero outside RUN, counts non-complete RUN cycles with
  // saturation, and is latched into run_cycles alongside result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_r    <= 32'd0;
      run_cycles_r <= 32'd0;
    end else if (state_r != RUN) begin
      cyc_cnt_r <= 32'd0;
    end else if (abort) begin
      cyc_cnt_r <= 32'd0;
    end else if (slv_complete) begin
      run_cycles_r <= cyc_cnt_r;
    end else if (cyc_cnt_r != 32'hFFFF_FFFF) begin
      cyc_cnt_r <= cyc_cnt_r + 32'd1;
    end
  end

  assign run_cycles = run_cycles_r;
`endif

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign result       = result_r;
  assign slv_rst      = slv_rst_r;
  assign slv_in_data1 = ram_rdata1;
  assign slv_in_data2 = ram_rdata2;

endmodule
